two_bit_seq: RTL

Instruction-fetch sequencer that reads and executes the 2-bit instruction ROM (`twoBitRam`-style addr→data, combinational read). It drives the ROM address, decodes the three-opcode ISA (INC 00, JNO 01, HLT 10), and maintains a program counter, an accumulator and a sticky overflow flag. It reports completion to the surrounding test harness via a start/halted handshake.

---
 rtl/two_bit_seq_pkg.sv | 29 ++
 rtl/two_bit_seq_acc.sv | 33 +++
 rtl/two_bit_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/two_bit_seq_pkg.sv
// ============================================================
// two_bit_seq_pkg : ISA opcodes, sequencer state and address types
// Revision 1.0
// ============================================================
`default_nettype none

package two_bit_seq_pkg;

   typedef logic [1:0] addr_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_OPERAND = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_JNO = 2'b01;
   localparam logic [1:0] OP_HLT = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   function automatic addr_t pc_inc(input addr_t pc);
      return pc + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/two_bit_seq_acc.sv
// ============================================================
// two_bit_seq_acc : ACC_W accumulator with clear, increment, sticky overflow
// Revision 1.0
// ============================================================
`default_nettype none

module two_bit_seq_acc #(
   parameter int ACC_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [ACC_W-1:0] acc,
   output logic             ovf
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         acc <= acc + ACC_W'(1);
         // wrapping from all-ones latches the flag until the next clear
         if (&acc) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/two_bit_seq.sv
// ============================================================
// two_bit_seq : 2-bit ROM instruction sequencer (INC / JNO / HLT)
// Opcode 11 traps to HALT when TWO_BIT_SEQ_ILLEGAL_TRAP_EN is defined, else NOP.
// Revision 1.0
// ============================================================
`default_nettype none

module two_bit_seq
   import two_bit_seq_pkg::*;
#(
   parameter int ACC_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       data,
   output logic [1:0]       addr,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic             busy,
   output logic             halted,
   output logic             illegal
);

   state_t state, state_nx;
   addr_t  pc, pc_nx;
   logic   acc_clr, acc_inc;
   logic   busy_nx, halted_nx;
   logic   illegal_nx;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         pc     <= '0;
         busy   <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         busy   <= busy_nx;
         halted <= halted_nx;
      end
   end

   // next-state and datapath control
   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      acc_clr    = 1'b0;
      acc_inc    = 1'b0;
      illegal_nx = illegal;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_nx   = ST_FETCH;
               pc_nx      = '0;
               acc_clr    = 1'b1;
               illegal_nx = 1'b0;
            end
         end
         ST_FETCH: begin
            case (data)
               OP_INC: begin
                  acc_inc = 1'b1;
                  pc_nx   = pc_inc(pc);
               end
               OP_JNO: begin
                  pc_nx    = pc_inc(pc);
                  state_nx = ST_OPERAND;
               end
               OP_HLT: begin
                  state_nx = ST_HALT;
               end
               OP_ILL: begin
`ifdef TWO_BIT_SEQ_ILLEGAL_TRAP_EN
                  state_nx   = ST_HALT;
                  illegal_nx = 1'b1;
`else
                  pc_nx = pc_inc(pc);
`endif
               end
               default: begin
                  state_nx = ST_IDLE;
               end
            endcase
         end
         ST_OPERAND: begin
            pc_nx    = ovf ? pc_inc(pc) : addr_t'(data);
            state_nx = ST_FETCH;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // status outputs are decoded from the next state so they register with it
   always_comb begin
      busy_nx   = (state_nx == ST_FETCH) || (state_nx == ST_OPERAND);
      halted_nx = (state_nx == ST_HALT);
   end

`ifdef TWO_BIT_SEQ_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_nx;
      end
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;

   logic unused_ok;
   assign unused_ok = illegal_nx;
`endif

   assign addr = pc;

   two_bit_seq_acc #(
      .ACC_W (ACC_W)
   ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .inc   (acc_inc),
      .acc   (acc),
      .ovf   (ovf)
   );

endmodule

`default_nettype wire
